// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the program ROM combinationally and
// buffers one instruction for decode over valid/ready; folds jmp and accepts redirects.
module fetch_unit #(
  parameter int ADDR_W = 4,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_instruction,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INST_W-1:0] if_instruction,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target
);

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              may_load;
  logic              is_jmp;
  logic [ADDR_W-1:0] jmp_target;

  assign rom_addr   = pc;
  // The buffer frees up either when empty or when its word leaves this cycle.
  assign may_load   = ~if_valid | if_ready;
  assign is_jmp     = (rom_instruction[INST_W-1 -: 4] == 4'b1000);
  assign jmp_target = rom_instruction[ADDR_W+7:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= '0;
      if_valid       <= 1'b0;
      if_instruction <= '0;
      if_pc          <= '0;
    end else begin
      case (state)
        IDLE: state <= RUN;
        default: begin
          if (redirect_valid) begin
            // Flush: any word in the buffer is dropped (or was just consumed).
            pc       <= redirect_target;
            if_valid <= 1'b0;
            state    <= RUN;
          end else if (may_load) begin
            if (is_jmp) begin
              pc       <= jmp_target;
              if_valid <= 1'b0;
            end else begin
              if_instruction <= rom_instruction;
              if_pc          <= pc;
              if_valid       <= 1'b1;
              pc             <= pc + ADDR_W'(1);
            end
            state <= RUN;
          end else begin
            state <= STALL;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: fixed vector table, hand sequences for the
// jmp/redirect/reset corners, and a randomized run against a spec-level model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rom_addr;
  logic [15:0] rom_instruction;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_instruction;
  logic [3:0]  if_pc;
  logic        redirect_valid;
  logic [3:0]  redirect_target;

  logic [15:0] rom [16];

  int checks = 0;
  int errors = 0;

  // Reference model state: what the fetch stage should hold after each edge.
  int          m_pc, m_ipc;
  bit          m_valid, m_run;
  logic [15:0] m_inst;

  typedef struct {
    logic       rdy;
    logic       rv;
    logic [3:0] tgt;
    logic       ev;
    logic [3:0] eipc;
    logic [3:0] eaddr;
  } vec_t;
  vec_t tbl [11];

  always #5 clk = ~clk;

  assign rom_instruction = rom[rom_addr];

  fetch_unit #(.ADDR_W(4), .INST_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rom_addr        (rom_addr),
    .rom_instruction (rom_instruction),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instruction  (if_instruction),
    .if_pc           (if_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ipc = 0; m_valid = 0; m_run = 0; m_inst = '0;
  endtask

  // One clock edge of the fetch rules, as stated: redirect > jmp > load > hold.
  task automatic model_step(input bit rdy, input bit rv, input int tgt);
    logic [15:0] w;
    if (!m_run) begin
      m_run = 1;
      return;
    end
    w = rom[m_pc];
    if (rv) begin
      m_pc = tgt; m_valid = 0;
    end else if (!m_valid || rdy) begin
      if (w[15:12] == 4'h8) begin
        m_pc = w[11:8]; m_valid = 0;
      end else begin
        m_inst = w; m_ipc = m_pc; m_valid = 1; m_pc = (m_pc + 1) % 16;
      end
    end
  endtask

  task automatic check_model();
    chk("rom_addr", rom_addr, m_pc);
    chk("if_valid", if_valid, m_valid);
    if (m_valid) begin
      chk("if_pc", if_pc, m_ipc);
      chk("if_instruction", if_instruction, m_inst);
    end
    chk("no_jmp_out", (if_valid && if_instruction[15:12] == 4'h8) ? 1 : 0, 0);
  endtask

  // Called at a negedge: drive inputs, take the edge, check at the next negedge.
  task automatic cycle(input bit rdy, input bit rv, input logic [3:0] tgt);
    if_ready = rdy; redirect_valid = rv; redirect_target = tgt;
    @(posedge clk);
    model_step(rdy, rv, int'(tgt));
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pc", rom_addr, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_inst", if_instruction, 0);
    chk("rst_ifpc", if_pc, 0);
    rst_n = 1'b1;
  endtask

  task automatic default_rom();
    for (int i = 0; i < 16; i++) rom[i] = 16'h2000 + 16'(i * 16'h0111);
  endtask

  initial begin
    int seen;
    bit exp_v [7];
    int exp_ipc [7];

    tbl[0]  = '{1'b1, 1'b0, 4'd0,  1'b0, 4'd0,  4'd0};
    tbl[1]  = '{1'b1, 1'b0, 4'd0,  1'b1, 4'd0,  4'd1};
    tbl[2]  = '{1'b0, 1'b0, 4'd0,  1'b1, 4'd0,  4'd1};
    tbl[3]  = '{1'b0, 1'b0, 4'd0,  1'b1, 4'd0,  4'd1};
    tbl[4]  = '{1'b1, 1'b0, 4'd0,  1'b1, 4'd1,  4'd2};
    tbl[5]  = '{1'b1, 1'b1, 4'd10, 1'b0, 4'd0,  4'd10};
    tbl[6]  = '{1'b1, 1'b0, 4'd0,  1'b1, 4'd10, 4'd11};
    tbl[7]  = '{1'b0, 1'b1, 4'd3,  1'b0, 4'd0,  4'd3};
    tbl[8]  = '{1'b0, 1'b0, 4'd0,  1'b1, 4'd3,  4'd4};
    tbl[9]  = '{1'b0, 1'b0, 4'd0,  1'b1, 4'd3,  4'd4};
    tbl[10] = '{1'b1, 1'b0, 4'd0,  1'b1, 4'd4,  4'd5};

    // Vector table: startup latency, stall, redirect, redirect during stall.
    default_rom();
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 11; i++) begin
      if_ready = tbl[i].rdy; redirect_valid = tbl[i].rv; redirect_target = tbl[i].tgt;
      @(posedge clk);
      model_step(tbl[i].rdy, tbl[i].rv, int'(tbl[i].tgt));
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), if_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_addr", i), rom_addr, tbl[i].eaddr);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_ifpc", i), if_pc, tbl[i].eipc);
        chk($sformatf("tbl%0d_inst", i), if_instruction, rom[tbl[i].eipc]);
      end
    end

    // Full sweep with if_ready=1: no bubbles, pc wraps 15 -> 0.
    do_reset();
    cycle(1'b1, 1'b1, 4'd7);  // redirect while IDLE is ignored
    chk("idle_redirect_addr", rom_addr, 0);
    for (int i = 0; i < 18; i++) begin
      cycle(1'b1, 1'b0, 4'd0);
      chk("sweep_valid", if_valid, 1);
      chk("sweep_ifpc", if_pc, i % 16);
    end

    // Hold if_ready low while pc 3 is buffered.
    do_reset();
    seen = 0;
    for (int i = 0; i < 20 && !(if_valid && if_pc == 4'd3); i++) cycle(1'b1, 1'b0, 4'd0);
    chk("stall_reached_pc3", (if_valid && if_pc == 4'd3) ? 1 : 0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 4'd0);
      chk("stall_ifpc", if_pc, 3);
      chk("stall_addr", rom_addr, 4);
    end
    cycle(1'b1, 1'b0, 4'd0);
    chk("stall_release_ifpc", if_pc, 4);

    // jmp back to 1: 0,1,bubble,1,bubble,1 ...
    default_rom();
    rom[0] = 16'hB401; rom[1] = 16'hF400; rom[2] = 16'h8100;
    do_reset();
    exp_v   = '{0, 1, 1, 0, 1, 0, 1};
    exp_ipc = '{0, 0, 1, 0, 1, 0, 1};
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, 1'b0, 4'd0);
      chk($sformatf("jmp_seq%0d_valid", i), if_valid, exp_v[i]);
      if (exp_v[i]) chk($sformatf("jmp_seq%0d_ifpc", i), if_pc, exp_ipc[i]);
    end
    // ROM now presents the jmp; redirect to 5 wins, and the transfer is not repeated.
    chk("jmp_present_addr", rom_addr, 2);
    cycle(1'b1, 1'b1, 4'd5);
    chk("redir_over_jmp_valid", if_valid, 0);
    chk("redir_over_jmp_addr", rom_addr, 5);
    cycle(1'b1, 1'b0, 4'd0);
    chk("redir_over_jmp_ifpc", if_pc, 5);
    chk("redir_over_jmp_inst", if_instruction, rom[5]);

    // Asynchronous reset mid-run, between edges.
    repeat (3) cycle(1'b1, 1'b0, 4'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", rom_addr, 0);
    chk("async_rst_valid", if_valid, 0);
    chk("async_rst_inst", if_instruction, 0);
    chk("async_rst_ifpc", if_pc, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 4'd0);
    chk("post_rst_idle_valid", if_valid, 0);
    cycle(1'b1, 1'b0, 4'd0);
    chk("post_rst_first_valid", if_valid, 1);
    chk("post_rst_first_ifpc", if_pc, 0);

    // Randomized ROM (with jmps, including self-jumps), ready and redirects.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) begin
        rom[i] = 16'($urandom);
        if ($urandom_range(3) == 0) rom[i][15:12] = 4'h8;
        else if (rom[i][15:12] == 4'h8) rom[i][15:12] = 4'h3;
      end
      do_reset();
      for (int i = 0; i < 250; i++)
        cycle($urandom_range(3) != 0, $urandom_range(6) == 0, 4'($urandom_range(15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
